control_unit: RTL and testbench

- Hardwired Moore control sequencer directly upstream of the datapath.
- Steps fetch (T0–T2) and per-opcode execute steps (T3–T7).
- Drives every datapath control strobe (register select, bus-out, register-in, memory, ALU opcode) from the IR contents and CON_FF.
- Replaces the hand-driven stimulus sequences.

---
 rtl/cu_pkg.sv | 77 +++++++
 rtl/control_unit.sv | 195 +++++++++++++++++++
 tb/tb_control_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the hardwired control sequencer: step encoding,
// opcode map, instruction classes and the opcode-to-class decode.
package cu_pkg;

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10101;
    localparam logic [4:0] OP_OUT  = 5'b10110;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        C_ALU3, C_IMM, C_LD, C_ST, C_MULDIV, C_BR, C_JR,
        C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HLT, C_BAD
    } iclass_t;

    function automatic iclass_t decode_class(input logic [4:0] opc);
        iclass_t cls;
        case (opc)
            OP_LD:                         cls = C_LD;
            OP_LDI, OP_ADDI:               cls = C_IMM;
            OP_ST:                         cls = C_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR: cls = C_ALU3;
            OP_MUL, OP_DIV:                cls = C_MULDIV;
            OP_BR:                         cls = C_BR;
            OP_JR:                         cls = C_JR;
            OP_IN:                         cls = C_IN;
            OP_OUT:                        cls = C_OUT;
            OP_MFHI:                       cls = C_MFHI;
            OP_MFLO:                       cls = C_MFLO;
            OP_NOP:                        cls = C_NOP;
            OP_HALT:                       cls = C_HLT;
            default:                       cls = C_BAD;
        endcase
        return cls;
    endfunction

    // Final step of each class; classes with no execute phase end at T2.
    function automatic state_t last_step(input iclass_t cls);
        state_t s;
        case (cls)
            C_ALU3, C_IMM:              s = S_T5;
            C_LD, C_ST:                 s = S_T7;
            C_MULDIV, C_BR:             s = S_T6;
            C_JR, C_IN, C_OUT,
            C_MFHI, C_MFLO:             s = S_T3;
            default:                    s = S_T2;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer: fetch T0-T2, per-class execute T3-T7.
// Optional build macro CU_ILLEGAL_TRAP_EN traps undefined opcodes into HALT.
module control_unit
    import cu_pkg::*;
#(
    parameter int OPC_W    = 5,
    parameter int MEM_WAIT = 0
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic [31:0]      IR,
    input  logic             CON_FF,
    input  logic             Stop,
    output logic             Run,
    output logic             Illegal,
    output logic [OPC_W-1:0] opcode,
    output logic             Read,
    output logic             Write,
    output logic             IncPC,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic             BAout,
    output logic             HIin,
    output logic             LOin,
    output logic             Yin,
    output logic             Zin,
    output logic             PCin,
    output logic             IRin,
    output logic             MARin,
    output logic             MDRin,
    output logic             Inportin,
    output logic             Outportin,
    output logic             CONin,
    output logic             HIout,
    output logic             LOout,
    output logic             Yout,
    output logic             Zhighout,
    output logic             Zlowout,
    output logic             PCout,
    output logic             MARout,
    output logic             MDRout,
    output logic             Inportout,
    output logic             Outportout,
    output logic             Cout
);

    localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);

    state_t     state;
    state_t     state_nxt;
    state_t     end_state;
    iclass_t    cls;
    logic [2:0] wait_cnt;
    logic       mem_step;
    logic       hold;
    logic       unused_ir_bits;

    assign cls            = decode_class(IR[31:27]);
    assign unused_ir_bits = ^IR[26:0];
    assign mem_step       = (state == S_T1) || (state == S_T6 && cls == C_LD);
    assign hold           = mem_step && (wait_cnt != 3'd0);
    assign end_state      = Stop ? S_HALT : S_T0;

    always_comb begin
        state_nxt = state;
        case (state)
            S_RST:  state_nxt = S_T0;
            S_HALT: state_nxt = S_HALT;
            default: begin
                if (hold)
                    state_nxt = state;
                else if (state == last_step(cls))
                    state_nxt = end_state;
                else
                    state_nxt = state_t'(state + 4'd1);
                if (state == S_T2 && cls == C_HLT)
                    state_nxt = S_HALT;
`ifdef CU_ILLEGAL_TRAP_EN
                if (state == S_T2 && cls == C_BAD)
                    state_nxt = S_HALT;
`endif
            end
        endcase
    end

    // The wait counter reloads on every step change and counts down while a
    // memory-read step is being held.
    always_ff @(posedge Clock) begin
        if (!clear) begin
            state    <= S_RST;
            wait_cnt <= WAIT_INIT;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                wait_cnt <= WAIT_INIT;
            else if (wait_cnt != 3'd0)
                wait_cnt <= wait_cnt - 3'd1;
        end
    end

`ifdef CU_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge Clock) begin
        if (!clear)
            illegal_q <= 1'b0;
        else if (state == S_T2 && cls == C_BAD)
            illegal_q <= 1'b1;
    end

    assign Illegal = illegal_q;
`else
    assign Illegal = 1'b0;
`endif

    always_comb begin
        Run = (state != S_HALT);
        opcode = (state == S_T4) ? IR[31:32-OPC_W] : '0;
        Read = 1'b0;      Write = 1'b0;      IncPC = 1'b0;
        Gra = 1'b0;       Grb = 1'b0;        Grc = 1'b0;
        Rin = 1'b0;       Rout = 1'b0;       BAout = 1'b0;
        HIin = 1'b0;      LOin = 1'b0;       Yin = 1'b0;
        Zin = 1'b0;       PCin = 1'b0;       IRin = 1'b0;
        MARin = 1'b0;     MDRin = 1'b0;      Inportin = 1'b0;
        Outportin = 1'b0; CONin = 1'b0;      HIout = 1'b0;
        LOout = 1'b0;     Yout = 1'b0;       Zhighout = 1'b0;
        Zlowout = 1'b0;   PCout = 1'b0;      MARout = 1'b0;
        MDRout = 1'b0;    Inportout = 1'b0;  Outportout = 1'b0;
        Cout = 1'b0;
        case (state)
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                case (cls)
                    C_ALU3:            begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    C_IMM, C_LD, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    C_MULDIV:          begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    C_BR:              begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    C_JR:              begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    C_IN:              begin Gra = 1'b1; Rin = 1'b1; Inportout = 1'b1; end
                    C_OUT:             begin Gra = 1'b1; Rout = 1'b1; Outportin = 1'b1; end
                    C_MFHI:            begin Gra = 1'b1; Rin = 1'b1; HIout = 1'b1; end
                    C_MFLO:            begin Gra = 1'b1; Rin = 1'b1; LOout = 1'b1; end
                    default:           ;
                endcase
            end
            S_T4: begin
                case (cls)
                    C_ALU3:            begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; end
                    C_IMM, C_LD, C_ST: begin Cout = 1'b1; Zin = 1'b1; end
                    C_MULDIV:          begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; end
                    C_BR:              begin PCout = 1'b1; Yin = 1'b1; end
                    default:           ;
                endcase
            end
            S_T5: begin
                case (cls)
                    C_ALU3, C_IMM:     begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_LD, C_ST:        begin Zlowout = 1'b1; MARin = 1'b1; end
                    C_MULDIV:          begin Zlowout = 1'b1; LOin = 1'b1; end
                    C_BR:              begin Cout = 1'b1; Zin = 1'b1; end
                    default:           ;
                endcase
            end
            S_T6: begin
                case (cls)
                    C_LD:              begin Read = 1'b1; MDRin = 1'b1; end
                    C_ST:              begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    C_MULDIV:          begin Zhighout = 1'b1; HIin = 1'b1; end
                    C_BR:              begin Zlowout = 1'b1; PCin = CON_FF; end
                    default:           ;
                endcase
            end
            S_T7: begin
                case (cls)
                    C_LD:              begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_ST:              Write = 1'b1;
                    default:           ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: two instances (MEM_WAIT 0 and 2) share
// stimulus; each test checks one instance cycle by cycle against a step table.
module tb_control_unit;

    localparam logic [30:0] M_READ     = 31'h1 << 0;
    localparam logic [30:0] M_WRITE    = 31'h1 << 1;
    localparam logic [30:0] M_INCPC    = 31'h1 << 2;
    localparam logic [30:0] M_GRA      = 31'h1 << 3;
    localparam logic [30:0] M_GRB      = 31'h1 << 4;
    localparam logic [30:0] M_GRC      = 31'h1 << 5;
    localparam logic [30:0] M_RIN      = 31'h1 << 6;
    localparam logic [30:0] M_ROUT     = 31'h1 << 7;
    localparam logic [30:0] M_BAOUT    = 31'h1 << 8;
    localparam logic [30:0] M_HIIN     = 31'h1 << 9;
    localparam logic [30:0] M_LOIN     = 31'h1 << 10;
    localparam logic [30:0] M_YIN      = 31'h1 << 11;
    localparam logic [30:0] M_ZIN      = 31'h1 << 12;
    localparam logic [30:0] M_PCIN     = 31'h1 << 13;
    localparam logic [30:0] M_IRIN     = 31'h1 << 14;
    localparam logic [30:0] M_MARIN    = 31'h1 << 15;
    localparam logic [30:0] M_MDRIN    = 31'h1 << 16;
    localparam logic [30:0] M_CONIN    = 31'h1 << 19;
    localparam logic [30:0] M_HIOUT    = 31'h1 << 20;
    localparam logic [30:0] M_LOOUT    = 31'h1 << 21;
    localparam logic [30:0] M_ZHIGHOUT = 31'h1 << 23;
    localparam logic [30:0] M_ZLOWOUT  = 31'h1 << 24;
    localparam logic [30:0] M_PCOUT    = 31'h1 << 25;
    localparam logic [30:0] M_MDROUT   = 31'h1 << 27;
    localparam logic [30:0] M_INPORTOUT = 31'h1 << 28;
    localparam logic [30:0] M_OUTPORTIN = 31'h1 << 18;
    localparam logic [30:0] M_COUT     = 31'h1 << 30;

    localparam logic [37:0] RST_V = {1'b1, 1'b0, 5'b0, 31'b0};

    logic        Clock = 1'b0;
    logic        clear = 1'b0;
    logic        CON_FF = 1'b0;
    logic        Stop = 1'b0;
    logic [31:0] IR = 32'h0;
    logic [37:0] obs [2];
    logic [37:0] sb_q [$];
    int          errors = 0;
    int          checks = 0;
    int          sel = 0;
    int          mw = 0;

    always #5 Clock = ~Clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic Run, Illegal, Read, Write, IncPC, Gra, Grb, Grc, Rin, Rout, BAout;
        logic HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Inportin, Outportin, CONin;
        logic HIout, LOout, Yout, Zhighout, Zlowout, PCout, MARout, MDRout;
        logic Inportout, Outportout, Cout;
        logic [4:0] opcode;

        control_unit #(.OPC_W(5), .MEM_WAIT(2 * g)) dut (
            .Clock(Clock), .clear(clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
            .Run(Run), .Illegal(Illegal), .opcode(opcode),
            .Read(Read), .Write(Write), .IncPC(IncPC),
            .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
            .HIin(HIin), .LOin(LOin), .Yin(Yin), .Zin(Zin), .PCin(PCin), .IRin(IRin),
            .MARin(MARin), .MDRin(MDRin), .Inportin(Inportin), .Outportin(Outportin),
            .CONin(CONin), .HIout(HIout), .LOout(LOout), .Yout(Yout),
            .Zhighout(Zhighout), .Zlowout(Zlowout), .PCout(PCout), .MARout(MARout),
            .MDRout(MDRout), .Inportout(Inportout), .Outportout(Outportout), .Cout(Cout)
        );

        assign obs[g] = {Run, Illegal, opcode, Cout, Outportout, Inportout, MDRout,
                         MARout, PCout, Zlowout, Zhighout, Yout, LOout, HIout, CONin,
                         Outportin, Inportin, MDRin, MARin, IRin, PCin, Zin, Yin, LOin,
                         HIin, BAout, Rout, Rin, Grc, Grb, Gra, IncPC, Write, Read};
    end

    task automatic check_output(input string tag, input logic [37:0] got, input logic [37:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s mw=%0d got=%h want=%h", tag, mw, got, want);
        end
    endtask

    task automatic push_step(input logic [30:0] s, input logic [4:0] opc, input int reps);
        for (int i = 0; i < reps; i++)
            sb_q.push_back({1'b1, 1'b0, opc, s});
    endtask

    task automatic push_halt(input logic ill, input int reps);
        for (int i = 0; i < reps; i++)
            sb_q.push_back({1'b0, ill, 5'b0, 31'b0});
    endtask

    task automatic push_fetch();
        push_step(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'b0, 1);
        push_step(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 5'b0, 1 + mw);
        push_step(M_MDROUT | M_IRIN, 5'b0, 1);
    endtask

    task automatic push_exec(input logic [4:0] opc, input logic con, output bit known);
        known = 1'b1;
        case (opc)
            5'b00011, 5'b00100, 5'b01010, 5'b01011: begin
                push_step(M_GRB | M_ROUT | M_YIN, 5'b0, 1);
                push_step(M_GRC | M_ROUT | M_ZIN, opc, 1);
                push_step(M_ZLOWOUT | M_GRA | M_RIN, 5'b0, 1);
            end
            5'b01100, 5'b00001: begin
                push_step(M_GRB | M_BAOUT | M_YIN, 5'b0, 1);
                push_step(M_COUT | M_ZIN, opc, 1);
                push_step(M_ZLOWOUT | M_GRA | M_RIN, 5'b0, 1);
            end
            5'b00000: begin
                push_step(M_GRB | M_BAOUT | M_YIN, 5'b0, 1);
                push_step(M_COUT | M_ZIN, opc, 1);
                push_step(M_ZLOWOUT | M_MARIN, 5'b0, 1);
                push_step(M_READ | M_MDRIN, 5'b0, 1 + mw);
                push_step(M_MDROUT | M_GRA | M_RIN, 5'b0, 1);
            end
            5'b00010: begin
                push_step(M_GRB | M_BAOUT | M_YIN, 5'b0, 1);
                push_step(M_COUT | M_ZIN, opc, 1);
                push_step(M_ZLOWOUT | M_MARIN, 5'b0, 1);
                push_step(M_GRA | M_ROUT | M_MDRIN, 5'b0, 1);
                push_step(M_WRITE, 5'b0, 1);
            end
            5'b01111, 5'b10000: begin
                push_step(M_GRA | M_ROUT | M_YIN, 5'b0, 1);
                push_step(M_GRB | M_ROUT | M_ZIN, opc, 1);
                push_step(M_ZLOWOUT | M_LOIN, 5'b0, 1);
                push_step(M_ZHIGHOUT | M_HIIN, 5'b0, 1);
            end
            5'b10011: begin
                push_step(M_GRA | M_ROUT | M_CONIN, 5'b0, 1);
                push_step(M_PCOUT | M_YIN, opc, 1);
                push_step(M_COUT | M_ZIN, 5'b0, 1);
                push_step(M_ZLOWOUT | (con ? M_PCIN : 31'b0), 5'b0, 1);
            end
            5'b10100: push_step(M_GRA | M_ROUT | M_PCIN, 5'b0, 1);
            5'b10101: push_step(M_GRA | M_RIN | M_INPORTOUT, 5'b0, 1);
            5'b10110: push_step(M_GRA | M_ROUT | M_OUTPORTIN, 5'b0, 1);
            5'b10111: push_step(M_GRA | M_RIN | M_HIOUT, 5'b0, 1);
            5'b11000: push_step(M_GRA | M_RIN | M_LOOUT, 5'b0, 1);
            5'b11010, 5'b11011: ;
            default: known = 1'b0;
        endcase
    endtask

    task automatic do_reset();
        @(negedge Clock);
        clear = 1'b0;
        @(posedge Clock);
        #1;
        check_output("reset", obs[sel], RST_V);
    endtask

    task automatic apply_stimulus(input logic [4:0] opc, input logic con, input logic stop);
        @(negedge Clock);
        IR = {opc, 27'($urandom)};
        CON_FF = con;
        Stop = stop;
        clear = 1'b1;
    endtask

    // Pops one expected vector per clock; abort_idx drops clear for one cycle.
    task automatic run_queue(input string tag, input int abort_idx);
        int idx = 0;
        logic [37:0] want;
        while (sb_q.size() > 0 && idx < 500) begin
            @(posedge Clock);
            #1;
            want = sb_q.pop_front();
            check_output($sformatf("%s[%0d]", tag, idx), obs[sel], want);
            if (idx == abort_idx) clear = 1'b0;
            if (idx == abort_idx + 1) clear = 1'b1;
            idx++;
        end
        sb_q.delete();
    endtask

    task automatic run_instr(input string tag, input logic [4:0] opc, input logic con, input logic stop);
        bit known;
        do_reset();
        push_fetch();
        push_exec(opc, con, known);
        if (opc == 5'b11011) begin
            push_halt(1'b0, 20);
        end else if (!known) begin
`ifdef CU_ILLEGAL_TRAP_EN
            push_halt(1'b1, 20);
`else
            if (stop) push_halt(1'b0, 20);
            else push_step(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'b0, 1);
`endif
        end else if (stop) begin
            push_halt(1'b0, 20);
        end else begin
            push_step(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'b0, 1);
        end
        apply_stimulus(opc, con, stop);
        run_queue(tag, -1);
    endtask

    task automatic run_abort();
        bit known;
        do_reset();
        push_fetch();
        push_exec(5'b01111, 1'b0, known);
        while (sb_q.size() > 6 + mw) void'(sb_q.pop_back());
        sb_q.push_back(RST_V);
        push_step(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'b0, 1);
        push_step(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 5'b0, 1);
        apply_stimulus(5'b01111, 1'b0, 1'b0);
        run_queue("mul_abort", 5 + mw);
    endtask

    initial begin
        logic [4:0] ops [13];
        ops = '{5'b00011, 5'b00100, 5'b01010, 5'b01011, 5'b01100, 5'b00001, 5'b00000,
                5'b00010, 5'b01111, 5'b10000, 5'b10100, 5'b10101, 5'b10110};
        for (int s = 0; s < 2; s++) begin
            sel = s;
            mw = 2 * s;
            run_instr("mflo", 5'b11000, 1'b0, 1'b0);
            for (int i = 0; i < 13; i++)
                run_instr($sformatf("op%b", ops[i]), ops[i], 1'b0, 1'b0);
            run_instr("mfhi", 5'b10111, 1'b0, 1'b0);
            run_instr("br_con0", 5'b10011, 1'b0, 1'b0);
            run_instr("br_con1", 5'b10011, 1'b1, 1'b0);
            run_instr("nop", 5'b11010, 1'b0, 1'b0);
            run_instr("halt", 5'b11011, 1'b0, 1'b0);
            run_instr("mflo_stop", 5'b11000, 1'b0, 1'b1);
            run_instr("undef", 5'b11111, 1'b0, 1'b0);
            run_abort();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
